// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-write FIFO between the data cache and data memory.
// Cache writes are acked in one cycle and drained to memory in the background.
// Reads hit in the buffer (youngest matching entry) or wait for a full drain.
module dmem_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_read_req,
   input  logic              c_write_req,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_write_data,
   output logic [DATA_W-1:0] c_read_data,
   output logic              c_read_valid,
   output logic              c_write_back_valid,
   output logic              m_read_req,
   output logic              m_write_req,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_write_data,
   input  logic [DATA_W-1:0] m_read_data,
   input  logic              m_read_valid,
   input  logic              m_write_back_valid,
   output logic              wb_empty
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} mstate_t;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       count, count_nxt;
   mstate_t           state, state_nxt;
   logic [ADDR_W-1:0] read_addr;
   logic              enq, pop, rd_pend, hit, fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   // The ack cycle masks the still-high request; fullness uses the registered count.
   assign enq     = c_write_req && (count < (PW+1)'(DEPTH)) && !c_write_back_valid;
   assign pop     = (state == M_WRITE) && m_write_back_valid;
   assign rd_pend = c_read_req && !c_read_valid && !c_write_req;
   // No forwarding while a memory read is in flight, so only one completion can occur.
   assign fwd_hit = rd_pend && hit && (state != M_READ);

   // CAM over valid entries, oldest to youngest, so the last match is the youngest.
   always_comb begin
      logic [PW-1:0] idx;
      hit      = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (((PW+1)'(i) < count) && (addr_q[idx] == c_addr)) begin
            hit      = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

   // Memory FSM next state: draining always beats a read miss.
   always_comb begin
      state_nxt = state;
      count_nxt = count + (PW+1)'(enq) - (PW+1)'(pop);
      case (state)
         M_IDLE: begin
            if (count != '0)           state_nxt = M_WRITE;
            else if (rd_pend && !hit)  state_nxt = M_READ;
         end
         M_WRITE: if (m_write_back_valid) state_nxt = M_IDLE;
         M_READ:  if (m_read_valid)       state_nxt = M_IDLE;
         default: state_nxt = M_IDLE;
      endcase
   end

   // Memory-side request outputs follow the state; address/data stable while requesting.
   always_comb begin
      m_write_req  = (state == M_WRITE);
      m_read_req   = (state == M_READ);
      m_addr       = '0;
      m_write_data = '0;
      if (state == M_WRITE) begin
         m_addr       = addr_q[rd_ptr];
         m_write_data = data_q[rd_ptr];
      end else if (state == M_READ) begin
         m_addr = read_addr;
      end
   end

   // FIFO storage; contents need no reset since count gates every use.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[wr_ptr] <= c_addr;
         data_q[wr_ptr] <= c_write_data;
      end
   end

   // Control state, pointers and registered cache-side responses.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         state              <= M_IDLE;
         read_addr          <= '0;
         c_read_data        <= '0;
         c_read_valid       <= 1'b0;
         c_write_back_valid <= 1'b0;
         wb_empty           <= 1'b1;
      end else begin
         state              <= state_nxt;
         count              <= count_nxt;
         c_write_back_valid <= enq;
         wb_empty           <= (count_nxt == '0) && (state_nxt == M_IDLE);
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (state == M_IDLE && state_nxt == M_READ) read_addr <= c_addr;
         c_read_valid <= 1'b0;
         if (fwd_hit) begin
            c_read_valid <= 1'b1;
            c_read_data  <= fwd_data;
         end else if (state == M_READ && m_read_valid) begin
            c_read_valid <= 1'b1;
            c_read_data  <= m_read_data;
         end
      end
   end

endmodule
